// File: rtl/cluster_eval_pkg.sv
// Shared state encoding, default cluster widths and counter helpers for the
// cluster evaluation sequencer and its compare block.
package cluster_eval_pkg;

    localparam int CLU_IN_W  = 1894;
    localparam int CLU_OUT_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } eval_state_e;

    // Increment v, holding at the all-ones value of a w-bit counter (w <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] top;
        top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v == top) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/cluster_eval_cmp.sv
// Compares cluster outputs against the held golden word and captures the
// first failing test (index and per-bit mismatch mask) of a run.
module cluster_eval_cmp
    import cluster_eval_pkg::*;
#(
    parameter int OUT_W = CLU_OUT_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             chk,
    input  logic [OUT_W-1:0] clu_out,
    input  logic [OUT_W-1:0] gold,
    input  logic [CNT_W-1:0] idx,
    output logic             mism_any,
    output logic             first_err_vld,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [OUT_W-1:0] first_err_mask
);

    logic [OUT_W-1:0] mism;

    assign mism     = clu_out ^ gold;
    assign mism_any = |mism;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            first_err_vld  <= 1'b0;
            first_err_idx  <= '0;
            first_err_mask <= '0;
        end else if (chk && mism_any && !first_err_vld) begin
            first_err_vld  <= 1'b1;
            first_err_idx  <= idx;
            first_err_mask <= mism;
        end
    end

endmodule

// File: rtl/cluster_eval_sequencer.sv
// Streams vector/golden pairs through a combinational output cluster, holds
// each vector SETTLE cycles, checks the result and keeps pass/fail counts.
module cluster_eval_sequencer
    import cluster_eval_pkg::*;
#(
    parameter int IN_W   = CLU_IN_W,
    parameter int OUT_W  = CLU_OUT_W,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_tests,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [IN_W-1:0]  vec_data,
    input  logic [OUT_W-1:0] vec_gold,
    output logic [IN_W-1:0]  clu_in,
    input  logic [OUT_W-1:0] clu_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] test_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [OUT_W-1:0] first_err_mask
);

    localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    eval_state_e      state_q, state_d;
    logic [SC_W-1:0]  settle_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] test_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [OUT_W-1:0] gold_q;
    logic [IN_W-1:0]  clu_in_q;
    logic             aborted_q;
    logic             start_run, hs, chk, mism_any, in_run, last_test;

    assign in_run    = (state_q == ST_ACCEPT) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign last_test = (test_cnt_q + CNT_W'(1)) == num_q;

    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        hs        = 1'b0;
        chk       = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // abort is deliberately not looked at here: start always wins
                if (start) begin
                    start_run = 1'b1;
                    state_d   = (num_tests == '0) ? ST_DONE : ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                hs = vec_valid;
                if (abort)          state_d = ST_DONE;
                else if (vec_valid) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort)                 state_d = ST_DONE;
                else if (settle_q == '0)   state_d = ST_CHECK;
            end
            ST_CHECK: begin
                chk = 1'b1;
                if (abort || last_test) state_d = ST_DONE;
                else                    state_d = ST_ACCEPT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            settle_q   <= '0;
            num_q      <= '0;
            test_cnt_q <= '0;
            err_cnt_q  <= '0;
            gold_q     <= '0;
            clu_in_q   <= '0;
            aborted_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_run) begin
                num_q      <= num_tests;
                test_cnt_q <= '0;
                err_cnt_q  <= '0;
                aborted_q  <= 1'b0;
            end
            if (in_run && abort)
                aborted_q <= 1'b1;
            // A handshake that coincides with abort still consumes the pair.
            if (hs) begin
                clu_in_q <= vec_data;
                gold_q   <= vec_gold;
                settle_q <= SC_W'(SETTLE - 1);
            end else if (state_q == ST_SETTLE && settle_q != '0) begin
                settle_q <= settle_q - SC_W'(1);
            end
            if (chk) begin
                test_cnt_q <= test_cnt_q + CNT_W'(1);
                if (mism_any)
                    err_cnt_q <= CNT_W'(sat_inc(64'(err_cnt_q), CNT_W));
            end
        end
    end

    cluster_eval_cmp #(
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) u_cmp (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (start_run),
        .chk            (chk),
        .clu_out        (clu_out),
        .gold           (gold_q),
        .idx            (test_cnt_q),
        .mism_any       (mism_any),
        .first_err_vld  (first_err_vld),
        .first_err_idx  (first_err_idx),
        .first_err_mask (first_err_mask)
    );

    assign vec_ready = (state_q == ST_ACCEPT);
    assign busy      = in_run;
    assign done      = (state_q == ST_DONE);
    assign aborted   = aborted_q;
    assign clu_in    = clu_in_q;
    assign test_cnt  = test_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_cluster_eval_sequencer.sv
// Scoreboard bench: stimulus plans each run and queues its expected outcome,
// a monitor checks every completed test and every finished run.
module tb_cluster_eval_sequencer;

    localparam int IN_W   = 1894;
    localparam int OUT_W  = 128;
    localparam int SETTLE = 2;
    localparam int CNT_W  = 32;
    localparam int HOP    = SETTLE + 2;

    typedef logic [OUT_W-1:0] wv_t;

    typedef struct {
        logic [CNT_W-1:0] tc;
        logic [CNT_W-1:0] ec;
        logic             fv;
        logic [CNT_W-1:0] fi;
        wv_t              fm;
        logic             ab;
    } run_t;

    logic             clk = 1'b0;
    logic             rst_n, start, abort, vec_valid;
    logic [CNT_W-1:0] num_tests;
    logic             vec_ready, busy, done, aborted, first_err_vld;
    logic [IN_W-1:0]  vec_data, clu_in;
    wv_t              vec_gold, clu_out, first_err_mask;
    logic [CNT_W-1:0] test_cnt, err_cnt, first_err_idx;

    cluster_eval_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_tests(num_tests), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_data(vec_data), .vec_gold(vec_gold), .clu_in(clu_in),
        .clu_out(clu_out), .busy(busy), .done(done), .aborted(aborted),
        .test_cnt(test_cnt), .err_cnt(err_cnt), .first_err_vld(first_err_vld),
        .first_err_idx(first_err_idx), .first_err_mask(first_err_mask)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic start_q = 1'b0;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        start_q <= start;
    end

    // Cluster stand-in whose result only becomes visible SETTLE cycles after
    // clu_in changes, so an early sample reads stale data.
    function automatic wv_t clu_fn(input logic [IN_W-1:0] v);
        return v[OUT_W-1:0] ^ v[IN_W-1 -: OUT_W] ^ {v[700 +: 64], v[300 +: 64]};
    endfunction

    wv_t clu_pipe [SETTLE];
    always @(posedge clk) begin
        clu_pipe[0] <= clu_fn(clu_in);
        for (int k = 1; k < SETTLE; k++) clu_pipe[k] <= clu_pipe[k-1];
    end
    assign clu_out = clu_pipe[SETTLE-1];

    int   total = 0;
    int   bad   = 0;
    run_t run_q[$];
    bit   vq[$];
    wv_t  flips [0:63];
    logic [IN_W-1:0] last_d;

    task automatic check(input string nm, input wv_t act, input wv_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic [CNT_W-1:0] prev_tc = '0;
    logic [CNT_W-1:0] prev_ec = '0;
    logic             prev_done = 1'b0;

    initial begin
        run_t r;
        bit   m;
        forever begin
            @(negedge clk);
            if (test_cnt == prev_tc + CNT_W'(1)) begin
                if (vq.size() == 0) begin
                    check("test_without_vector", 1, 0);
                end else begin
                    m = vq.pop_front();
                    check("err_step", wv_t'(err_cnt), wv_t'(prev_ec) + wv_t'(m));
                end
            end
            if (done && (!prev_done || start_q)) begin
                if (run_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    r = run_q.pop_front();
                    check("run_test_cnt", wv_t'(test_cnt), wv_t'(r.tc));
                    check("run_err_cnt", wv_t'(err_cnt), wv_t'(r.ec));
                    check("run_first_vld", wv_t'(first_err_vld), wv_t'(r.fv));
                    check("run_first_idx", wv_t'(first_err_idx), wv_t'(r.fi));
                    check("run_first_mask", first_err_mask, r.fm);
                    check("run_aborted", wv_t'(aborted), wv_t'(r.ab));
                    check("run_busy_low", wv_t'({busy, vec_ready}), 0);
                end
                vq.delete();
            end
            prev_tc   = test_cnt;
            prev_ec   = err_cnt;
            prev_done = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic mk_vec(input wv_t flip, output logic [IN_W-1:0] d, output wv_t g);
        logic [IN_W+31:0] t;
        for (int i = 0; i < IN_W; i += 32) t[i +: 32] = $urandom();
        d = t[IN_W-1:0];
        g = clu_fn(d) ^ flip;
    endtask

    // Present a pair and hold it until the handshake; returns one cycle later.
    task automatic send(input logic [IN_W-1:0] d, input wv_t g, input bit m, output int hs_cyc);
        vec_data  = d;
        vec_gold  = g;
        vec_valid = 1'b1;
        hs_cyc    = -1;
        for (int c = 0; c < 200; c++) begin
            if (vec_ready) begin
                hs_cyc = cyc;
                vq.push_back(m);
                last_d = d;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        check("handshake_timeout", 0, 1);
    endtask

    task automatic do_run(input int n, input int ab_at, input bit ab_chk, input int gapmax,
                          input bit start_abort, input bit b2b_check, input bit gap_check);
        run_t r;
        int   ndone, sc, hs, hs_prev, dcyc, rdy;
        logic [IN_W-1:0] d;
        wv_t  g;
        r = '{tc: '0, ec: '0, fv: 1'b0, fi: '0, fm: '0, ab: 1'b0};
        ndone = (ab_at < 0) ? n : (ab_chk ? ab_at + 1 : ab_at);
        for (int i = 0; i < ndone; i++) begin
            if (flips[i] != '0) begin
                r.ec++;
                if (!r.fv) begin
                    r.fv = 1'b1;
                    r.fi = CNT_W'(i);
                    r.fm = flips[i];
                end
            end
        end
        r.tc = CNT_W'(ndone);
        r.ab = (ab_at >= 0);
        run_q.push_back(r);

        num_tests = CNT_W'(n);
        start     = 1'b1;
        abort     = start_abort;
        sc        = cyc;
        @(negedge clk);
        start   = 1'b0;
        abort   = 1'b0;
        hs_prev = 0;
        if (n == 0) check("zero_no_ready", wv_t'(vec_ready), 0);
        for (int i = 0; i < n; i++) begin
            if (gap_check && i == 1) begin
                vec_valid = 1'b0;
                for (int c = 0; c < 50 && !vec_ready; c++) @(negedge clk);
                rdy = 0;
                for (int k = 0; k < 5; k++) begin
                    if (k == 2) begin
                        num_tests = $urandom();
                        start     = 1'b1;
                    end else begin
                        start = 1'b0;
                    end
                    @(negedge clk);
                    rdy += int'(vec_ready);
                end
                start = 1'b0;
                check("gap_ready_held", wv_t'(rdy), 5);
                check("gap_clu_in_held", wv_t'(clu_in != last_d), 0);
                check("gap_test_cnt", wv_t'(test_cnt), 1);
            end else if (gapmax > 0) begin
                vec_valid = 1'b0;
                repeat ($urandom_range(gapmax, 0)) @(negedge clk);
            end
            mk_vec(flips[i], d, g);
            send(d, g, flips[i] != '0, hs);
            if (b2b_check && i > 0) check("b2b_spacing", wv_t'(hs - hs_prev), HOP);
            hs_prev = hs;
            if (i == ab_at) begin
                if (ab_chk) repeat (SETTLE) @(negedge clk);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                break;
            end
        end
        vec_valid = 1'b0;
        dcyc = -1;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                dcyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (dcyc < 0) check("done_timeout", 0, 1);
        else if (b2b_check) check("b2b_done_latency", wv_t'(dcyc - sc), wv_t'(1 + n * HOP));
        else if (n == 0) check("zero_done_latency", wv_t'(dcyc - sc), 1);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

    initial begin
        int   n, ab, hs;
        logic [IN_W-1:0] d;
        wv_t  g;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_tests = '0;
        vec_valid = 1'b0; vec_data = '0; vec_gold = '0; last_d = '0;
        for (int i = 0; i < 64; i++) flips[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", wv_t'(busy), 0);
        check("rst_done", wv_t'(done), 0);
        check("rst_ready", wv_t'(vec_ready), 0);
        check("rst_counts", wv_t'({test_cnt, err_cnt}), 0);
        check("rst_first_err", wv_t'(first_err_vld) | first_err_mask | wv_t'(first_err_idx), 0);
        check("rst_clu_in", wv_t'(clu_in != '0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_run(0, -1, 0, 0, 0, 0, 0);                 // empty run from IDLE
        do_run(4, -1, 0, 0, 0, 1, 0);                 // back-to-back, all matching
        flips[2] = wv_t'(1) << 91;
        flips[4] = wv_t'(8'h81);
        do_run(5, -1, 0, 2, 0, 0, 0);                 // errors at tests 2 and 4
        for (int i = 0; i < 64; i++) flips[i] = '0;
        flips[5] = wv_t'(1) << 3;
        do_run(10, 3, 0, 1, 0, 0, 0);                 // abort in SETTLE of test 3
        flips[5] = '0;
        do_run(1, -1, 0, 0, 0, 0, 0);                 // aborted flag cleared
        flips[0] = wv_t'(1) << 127;
        do_run(3, -1, 0, 0, 0, 0, 1);                 // valid gap + ignored start
        flips[0] = '0;
        flips[1] = wv_t'(1) << 64;
        do_run(4, 1, 1, 0, 0, 0, 0);                  // abort coinciding with CHECK
        flips[1] = '0;
        do_run(2, -1, 0, 0, 1, 0, 0);                 // start and abort together
        do_run(0, -1, 0, 0, 0, 0, 0);                 // empty run from DONE

        // reset during SETTLE
        num_tests = CNT_W'(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mk_vec('0, d, g);
        send(d, g, 1'b0, hs);
        vec_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_state", wv_t'({busy, done, vec_ready, aborted}), 0);
        check("midrst_counts", wv_t'({test_cnt, err_cnt}), 0);
        check("midrst_clu_in", wv_t'(clu_in != '0), 0);
        rst_n = 1'b1;
        vq.delete();
        @(negedge clk);

        for (int r = 0; r < 10; r++) begin
            n  = $urandom_range(8, 1);
            ab = ($urandom_range(3, 0) == 0) ? $urandom_range(n - 1, 0) : -1;
            for (int i = 0; i < 64; i++) begin
                case ($urandom_range(3, 0))
                    0:       flips[i] = wv_t'(1) << $urandom_range(OUT_W - 1, 0);
                    1:       flips[i] = {$urandom(), $urandom(), $urandom(), $urandom()} | wv_t'(1);
                    default: flips[i] = '0;
                endcase
            end
            do_run(n, ab, 1'($urandom_range(1, 0)), $urandom_range(3, 0),
                   1'($urandom_range(1, 0)), 0, 0);
        end

        repeat (3) @(negedge clk);
        check("runs_drained", wv_t'(run_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
